nvram_upload: RTL and testbench

NVRAM_UPLOAD -- requirements
Module: nvram_upload

---
 rtl/nvram_upload_pkg.sv | 24 ++
 rtl/nvram_upload.sv | 130 +++++++++++++
 tb/tb_nvram_upload.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/nvram_upload_pkg.sv
// Shared definitions for the NVRAM upload path: CMOS geometry, the FSM state type
// and the byte returned for addresses beyond the CMOS array.
package nvram_upload_pkg;

  localparam int unsigned NV_DEPTH = 1024;
  localparam int unsigned NV_BYTES = 512;
  localparam int unsigned NV_AW    = $clog2(NV_DEPTH);
  localparam logic [7:0]  NV_FILL  = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StPause,
    StReady,
    StFetchLo,
    StFetchHi,
    StLatch
  } nv_state_e;

  // A byte address maps onto two CMOS nibbles only below NV_BYTES.
  function automatic logic nv_in_range(input logic [24:0] addr);
    return addr < 25'(NV_BYTES);
  endfunction

endpackage

// File: rtl/nvram_upload.sv
// Serves HPS byte reads of the nibble-wide CMOS RAM: halts the CPU, then assembles each
// byte from two consecutive nibble reads with a fixed four-cycle latency.
module nvram_upload
  import nvram_upload_pkg::*;
#(
  parameter int unsigned NV_INDEX = 4
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic [15:0]         ioctl_index,
  input  logic                ioctl_rd,
  input  logic [24:0]         ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                pause_req,
  input  logic                pause_ack,
  output logic [NV_AW-1:0]    nv_addr,
  output logic                nv_rd,
  input  logic [3:0]          nv_dout,
  output logic                busy
);

  nv_state_e        r_state, w_state_next;
  logic [24:0]      r_addr, w_addr_next;
  logic             r_pending, w_pending_next;
  logic [3:0]       r_lo, w_lo_next;
  logic [3:0]       r_hi, w_hi_next;
  logic [7:0]       r_din, w_din_next;
  logic [NV_AW-1:0] r_nv_addr, w_nv_addr_next;
  logic             r_nv_rd, w_nv_rd_next;
  logic             r_pause_req, w_pause_req_next;
  logic             r_wait, w_wait_next;
  logic             w_active;

  assign w_active = ioctl_upload && (ioctl_index == 16'(NV_INDEX));

  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_pending_next = r_pending;
    w_lo_next      = r_lo;
    w_hi_next      = r_hi;
    w_din_next     = r_din;
    w_nv_addr_next = r_nv_addr;

    if (!w_active && r_state != StIdle) begin
      w_state_next   = StIdle;
      w_pending_next = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_active) w_state_next = StPause;
        end
        StPause: begin
          // A read issued before the bus is granted is held until READY.
          if (ioctl_rd) begin
            w_addr_next    = ioctl_addr;
            w_pending_next = 1'b1;
          end
          if (pause_ack) w_state_next = StReady;
        end
        StReady: begin
          if (ioctl_rd || r_pending) begin
            if (ioctl_rd) w_addr_next = ioctl_addr;
            w_pending_next = 1'b0;
            w_state_next   = StFetchLo;
            if (nv_in_range(w_addr_next)) w_nv_addr_next = {w_addr_next[NV_AW-2:0], 1'b0};
          end
        end
        StFetchLo: begin
          w_state_next = StFetchHi;
          if (nv_in_range(r_addr)) w_nv_addr_next = {r_addr[NV_AW-2:0], 1'b1};
        end
        StFetchHi: begin
          w_lo_next    = nv_dout;
          w_state_next = StLatch;
        end
        StLatch: begin
          w_hi_next    = nv_dout;
          w_din_next   = nv_in_range(r_addr) ? {nv_dout, r_lo} : NV_FILL;
          w_state_next = StReady;
        end
        default: w_state_next = StIdle;
      endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    w_pause_req_next = (w_state_next != StIdle);
    w_nv_rd_next     = (w_state_next == StFetchLo || w_state_next == StFetchHi) &&
                       nv_in_range(w_addr_next);
    w_wait_next      = (w_state_next == StPause)   || (w_state_next == StFetchLo) ||
                       (w_state_next == StFetchHi) || (w_state_next == StLatch)   ||
                       (w_state_next == StReady && w_pending_next);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_pending   <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_din       <= 8'h00;
      r_nv_addr   <= '0;
      r_nv_rd     <= 1'b0;
      r_pause_req <= 1'b0;
      r_wait      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_pending   <= w_pending_next;
      r_lo        <= w_lo_next;
      r_hi        <= w_hi_next;
      r_din       <= w_din_next;
      r_nv_addr   <= w_nv_addr_next;
      r_nv_rd     <= w_nv_rd_next;
      r_pause_req <= w_pause_req_next;
      r_wait      <= w_wait_next;
    end
  end

  assign ioctl_din  = r_din;
  assign ioctl_wait = r_wait;
  assign pause_req  = r_pause_req;
  assign nv_addr    = r_nv_addr;
  assign nv_rd      = r_nv_rd;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_nvram_upload.sv
// Directed bench for nvram_upload with a nibble-wide CMOS model that answers one cycle
// after nv_rd.
module tb_nvram_upload;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [15:0] ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack;
  logic [9:0]  nv_addr;
  logic        nv_rd;
  logic [3:0]  nv_dout = 4'h0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem [0:1023];

  nvram_upload #(.NV_INDEX(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .nv_addr      (nv_addr),
    .nv_rd        (nv_rd),
    .nv_dout      (nv_dout),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (nv_rd) nv_dout <= mem[nv_addr];
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic seen_bad;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    mem[10'h010] = 4'h3;  mem[10'h011] = 4'hA;
    mem[10'h000] = 4'h5;  mem[10'h001] = 4'hC;
    mem[10'h3FE] = 4'h7;  mem[10'h3FF] = 4'hE;

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 16'd4; ioctl_rd = 1'b0;
    ioctl_addr = '0; pause_ack = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_pause_req", 32'(pause_req), 32'h0);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_nv_rd", 32'(nv_rd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_nv_addr", 32'(nv_addr), 32'h0);

    // Basic read: A=8 -> nibbles 0x10/0x11 -> 8'hA3.
    ioctl_upload = 1'b1;
    cyc();
    chk("pause_req", 32'(pause_req), 32'h1);
    chk("pause_wait", 32'(ioctl_wait), 32'h1);
    chk("pause_busy", 32'(busy), 32'h1);
    pause_ack = 1'b1;
    cyc();
    chk("ready_wait", 32'(ioctl_wait), 32'h0);
    chk("ready_pause_req", 32'(pause_req), 32'h1);
    ioctl_rd = 1'b1; ioctl_addr = 25'd8;
    cyc();
    ioctl_rd = 1'b0;
    chk("t1_nv_rd", 32'(nv_rd), 32'h1);
    chk("t1_nv_addr", 32'(nv_addr), 32'h010);
    chk("t1_wait", 32'(ioctl_wait), 32'h1);
    cyc();
    chk("t2_nv_rd", 32'(nv_rd), 32'h1);
    chk("t2_nv_addr", 32'(nv_addr), 32'h011);
    chk("t2_wait", 32'(ioctl_wait), 32'h1);
    cyc();
    chk("t3_wait", 32'(ioctl_wait), 32'h1);
    chk("t3_nv_rd", 32'(nv_rd), 32'h0);
    cyc();
    chk("t4_wait", 32'(ioctl_wait), 32'h0);
    chk("t4_din", 32'(ioctl_din), 32'hA3);

    // Pause handshake with a read issued while waiting for the bus.
    ioctl_upload = 1'b0; pause_ack = 1'b0;
    cyc();
    chk("drop_pause_req", 32'(pause_req), 32'h0);
    ioctl_upload = 1'b1;
    cyc();
    ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    cyc();
    ioctl_rd = 1'b0;
    seen_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ioctl_wait !== 1'b1 || nv_rd !== 1'b0 || pause_req !== 1'b1) seen_bad = 1'b1;
      cyc();
    end
    chk("pause_hold", 32'(seen_bad), 32'h0);
    pause_ack = 1'b1;
    cyc();
    chk("pend_ready_wait", 32'(ioctl_wait), 32'h1);
    chk("pend_ready_nv_rd", 32'(nv_rd), 32'h0);
    cyc();
    chk("pend_t1_nv_rd", 32'(nv_rd), 32'h1);
    chk("pend_t1_nv_addr", 32'(nv_addr), 32'h000);
    cyc(); cyc();
    chk("pend_t3_wait", 32'(ioctl_wait), 32'h1);
    cyc();
    chk("pend_t4_wait", 32'(ioctl_wait), 32'h0);
    chk("pend_t4_din", 32'(ioctl_din), 32'hC5);

    // Out of range: A=600 -> no CMOS access, 8'hFF, nv_addr keeps 0x001.
    ioctl_rd = 1'b1; ioctl_addr = 25'd600;
    cyc();
    ioctl_rd = 1'b0;
    seen_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (nv_rd !== 1'b0 || ioctl_wait !== 1'b1) seen_bad = 1'b1;
      cyc();
    end
    chk("oor_seq", 32'(seen_bad), 32'h0);
    chk("oor_wait", 32'(ioctl_wait), 32'h0);
    chk("oor_din", 32'(ioctl_din), 32'hFF);
    chk("oor_nv_addr", 32'(nv_addr), 32'h001);

    // Top in-range byte A=511, with a stray strobe mid-fetch that must be ignored.
    ioctl_rd = 1'b1; ioctl_addr = 25'd511;
    cyc();
    ioctl_addr = 25'd0;
    chk("top_t1_nv_addr", 32'(nv_addr), 32'h3FE);
    cyc();
    ioctl_rd = 1'b0;
    chk("top_t2_nv_addr", 32'(nv_addr), 32'h3FF);
    cyc(); cyc();
    chk("top_t4_wait", 32'(ioctl_wait), 32'h0);
    chk("top_t4_din", 32'(ioctl_din), 32'hE7);
    cyc();
    chk("top_idle_nv_rd", 32'(nv_rd), 32'h0);

    // Abort during FETCH_HI.
    ioctl_rd = 1'b1; ioctl_addr = 25'd8;
    cyc();
    ioctl_rd = 1'b0;
    cyc();
    ioctl_upload = 1'b0;
    cyc();
    chk("abort_pause_req", 32'(pause_req), 32'h0);
    chk("abort_wait", 32'(ioctl_wait), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_nv_rd", 32'(nv_rd), 32'h0);
    chk("abort_din_hold", 32'(ioctl_din), 32'hE7);

    // Wrong index: nothing happens.
    ioctl_upload = 1'b1; ioctl_index = 16'd0; ioctl_rd = 1'b1; ioctl_addr = 25'd8;
    seen_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (pause_req !== 1'b0 || nv_rd !== 1'b0 || ioctl_wait !== 1'b0 || busy !== 1'b0)
        seen_bad = 1'b1;
    end
    ioctl_rd = 1'b0;
    chk("wrong_index", 32'(seen_bad), 32'h0);

    // Reset while in LATCH.
    ioctl_index = 16'd4;
    cyc();
    cyc();
    ioctl_rd = 1'b1; ioctl_addr = 25'd8;
    cyc();
    ioctl_rd = 1'b0;
    cyc(); cyc();
    chk("pre_rst_wait", 32'(ioctl_wait), 32'h1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_pause_req", 32'(pause_req), 32'h0);
    chk("mid_rst_wait", 32'(ioctl_wait), 32'h0);
    chk("mid_rst_nv_rd", 32'(nv_rd), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_din", 32'(ioctl_din), 32'h00);
    chk("mid_rst_nv_addr", 32'(nv_addr), 32'h0);
    reset = 1'b0; ioctl_upload = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
